switch_checker: RTL

Synthesizable stimulus/response engine for a single-bit CMOS switch cell.
- Drives the switch input with an alternating 0,1,0,1… vector sequence.
- After a programmable settle time per vector, samples the switch output and compares it against the expected value.
- Counts mismatches and reports pass/fail. It is the clocked counterpart of the switch, so switch cells can be self-checked in silicon or in a clocked bench.

---
 rtl/switch_checker.sv | 121 ++++++++++++
 1 files changed

// File: rtl/switch_checker.sv
// Clocked stimulus/response checker for a single-bit switch cell: drives an
// alternating 0,1,0,1 vector stream, samples the cell output after a settle time.
module switch_checker #(
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned NUM_VEC = 4,
  parameter int unsigned CNT_W   = 8,
  parameter bit          INVERT  = 1'b1,
  localparam int unsigned VEC_W  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             inp,
  input  logic             out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [VEC_W-1:0] vec_idx
);

  localparam int unsigned SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [SET_W-1:0] CNT_LAST = SET_W'(SETTLE_LAST);
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [SET_W-1:0]   cnt, cnt_n;
  logic               inp_n, busy_n, done_n, pass_n;
  logic [CNT_W-1:0]   err_n;
  logic [VEC_W-1:0]   vec_n;
  logic               mismatch;

  // Anything other than a clean expected level (including X/Z) is a mismatch.
  assign mismatch = (out === (inp ^ INVERT)) ? 1'b0 : 1'b1;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      inp     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
      vec_idx <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      inp     <= inp_n;
      busy    <= busy_n;
      done    <= done_n;
      pass    <= pass_n;
      err_cnt <= err_n;
      vec_idx <= vec_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    inp_n   = inp;
    pass_n  = pass;
    err_n   = err_cnt;
    vec_n   = vec_idx;

    case (state)
      ST_IDLE: begin
        if (start) begin
          inp_n   = 1'b0;
          vec_n   = '0;
          err_n   = '0;
          pass_n  = 1'b0;
          cnt_n   = '0;
          state_n = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_n = cnt + SET_W'(1);
        if (cnt == CNT_LAST) begin
          state_n = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (mismatch && (err_cnt != ERR_MAX)) begin
          err_n = err_cnt + CNT_W'(1);
        end
        if (vec_idx == LAST_VEC) begin
          state_n = ST_DONE;
          pass_n  = (err_n == '0);
        end else begin
          vec_n   = vec_idx + VEC_W'(1);
          inp_n   = ~inp;
          cnt_n   = '0;
          state_n = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n == ST_SETTLE) || (state_n == ST_SAMPLE);
    done_n = (state_n == ST_DONE);
  end

endmodule
